acesso_memoria_dados: RTL and testbench

ACESSO_MEMORIA_DADOS -- requirements
Module: acesso_memoria_dados

---
 rtl/acesso_memoria_dados_pkg.sv | 35 +++
 rtl/acesso_memoria_dados_contador_timeout.sv | 42 ++++
 rtl/acesso_memoria_dados.sv | 135 +++++++++++++
 tb/tb_acesso_memoria_dados.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/acesso_memoria_dados_pkg.sv
// Shared CPU package: data-memory access FSM states,
// access descriptor and default timeout.
package acesso_memoria_dados_pkg;

  localparam int unsigned LARG_DADO          = 16;
  localparam int unsigned LARG_CONT          = 8;
  localparam int unsigned TIMEOUT_MAX_PADRAO = 15;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    REQUISICAO = 2'd1,
    ESPERA     = 2'd2,
    FIM        = 2'd3
  } estado_t;

  typedef struct packed {
    logic                 escrita;
    logic [LARG_DADO-1:0] endereco;
    logic [LARG_DADO-1:0] dado;
  } acesso_t;

  // Store wins when both requests arrive together.
  function automatic acesso_t novo_acesso(
    input logic                 esc,
    input logic [LARG_DADO-1:0] ender,
    input logic [LARG_DADO-1:0] dado
  );
    acesso_t a;
    a.escrita  = esc;
    a.endereco = ender;
    a.dado     = dado;
    return a;
  endfunction

endpackage

// File: rtl/acesso_memoria_dados_contador_timeout.sv
// Wait-cycle counter for the data-memory access FSM;
// hit flags the cycle on which the count reaches the limit.
module contador_timeout
  import acesso_memoria_dados_pkg::*;
#(
  parameter int unsigned LARGURA = LARG_CONT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               limpar,
  input  logic               habilitar,
  input  logic [LARGURA-1:0] limite,
  output logic               atingiu
);

  logic [LARGURA-1:0] contagem_q;
  logic [LARGURA-1:0] contagem_d;
  logic [LARGURA:0]   proxima;

  assign proxima = {1'b0, contagem_q}
                 + {{LARGURA{1'b0}}, 1'b1};

  assign atingiu = (proxima == {1'b0, limite});

  always_comb begin
    contagem_d = contagem_q;
    if (limpar) begin
      contagem_d = '0;
    end else if (habilitar) begin
      contagem_d = proxima[LARGURA-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

endmodule

// File: rtl/acesso_memoria_dados.sv
// Data-memory access unit: one outstanding load/store,
// stalls the pipeline and aborts on memory timeout.
module acesso_memoria_dados
  import acesso_memoria_dados_pkg::*;
#(
  parameter int unsigned TIMEOUT_MAX = TIMEOUT_MAX_PADRAO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_leitura,
  input  logic                 req_escrita,
  input  logic [LARG_DADO-1:0] endereco,
  input  logic [LARG_DADO-1:0] dado_escrita,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [LARG_DADO-1:0] mem_addr,
  output logic [LARG_DADO-1:0] mem_wdata,
  input  logic [LARG_DADO-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [LARG_DADO-1:0] dado_lido,
  output logic                 stall,
  output logic                 concluido,
  output logic                 erro_timeout
);

  localparam logic [LARG_CONT-1:0] LIMITE =
    LARG_CONT'(TIMEOUT_MAX);

  estado_t              estado_q, estado_d;
  acesso_t              acesso_q, acesso_d;
  logic                 mem_req_q, mem_req_d;
  logic [LARG_DADO-1:0] dado_lido_q, dado_lido_d;
  logic                 concluido_q, concluido_d;
  logic                 erro_q, erro_d;

  logic pedido;
  logic limpar_cont;
  logic habil_cont;
  logic atingiu;

  assign pedido = req_leitura | req_escrita;

  assign limpar_cont = (estado_q == REQUISICAO);
  assign habil_cont  = (estado_q == ESPERA) & ~mem_ready;

  contador_timeout #(
    .LARGURA (LARG_CONT)
  ) u_contador (
    .clk       (clk),
    .rst_n     (rst_n),
    .limpar    (limpar_cont),
    .habilitar (habil_cont),
    .limite    (LIMITE),
    .atingiu   (atingiu)
  );

  always_comb begin
    estado_d    = estado_q;
    acesso_d    = acesso_q;
    mem_req_d   = mem_req_q;
    dado_lido_d = dado_lido_q;
    concluido_d = 1'b0;
    erro_d      = erro_q;
    unique case (estado_q)
      OCIOSO: begin
        if (pedido) begin
          acesso_d  = novo_acesso(req_escrita,
                                  endereco,
                                  dado_escrita);
          mem_req_d = 1'b1;
          estado_d  = REQUISICAO;
        end
      end
      REQUISICAO: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        // Completion takes priority over an expiring count.
        if (mem_ready) begin
          if (!acesso_q.escrita) begin
            dado_lido_d = mem_rdata;
          end
          mem_req_d   = 1'b0;
          concluido_d = 1'b1;
          estado_d    = FIM;
        end else if (atingiu) begin
          erro_d      = 1'b1;
          mem_req_d   = 1'b0;
          concluido_d = 1'b1;
          estado_d    = FIM;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d  = OCIOSO;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      acesso_q    <= '0;
      mem_req_q   <= 1'b0;
      dado_lido_q <= '0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      acesso_q    <= acesso_d;
      mem_req_q   <= mem_req_d;
      dado_lido_q <= dado_lido_d;
      concluido_q <= concluido_d;
      erro_q      <= erro_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = acesso_q.escrita;
  assign mem_addr     = acesso_q.endereco;
  assign mem_wdata    = acesso_q.dado;
  assign dado_lido    = dado_lido_q;
  assign concluido    = concluido_q;
  assign erro_timeout = erro_q;

  // Gated by rst_n so a held request cannot stall during reset.
  assign stall = rst_n & (
      (estado_q == REQUISICAO)
    | (estado_q == ESPERA)
    | ((estado_q == OCIOSO) & pedido));

endmodule

// File: tb/tb_acesso_memoria_dados.sv
// Randomized bench for acesso_memoria_dados against a
// transaction-level model of the access timeline.
module tb_acesso_memoria_dados;

  localparam int TMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_leitura = 1'b0;
  logic        req_escrita = 1'b0;
  logic [15:0] endereco = '0;
  logic [15:0] dado_escrita = '0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] dado_lido;
  logic        stall;
  logic        concluido;
  logic        erro_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_dado = '0;
  bit          exp_erro = 1'b0;

  always #5 clk = ~clk;

  acesso_memoria_dados #(
    .TIMEOUT_MAX (TMAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_leitura  (req_leitura),
    .req_escrita  (req_escrita),
    .endereco     (endereco),
    .dado_escrita (dado_escrita),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .dado_lido    (dado_lido),
    .stall        (stall),
    .concluido    (concluido),
    .erro_timeout (erro_timeout)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Entered and left at posedge+1. k = ESPERA cycle on which
  // memory answers; k > TMAX means it never answers.
  task automatic run_txn(input logic w, input logic r,
                         input logic [15:0] a,
                         input logic [15:0] wd,
                         input logic [15:0] rd,
                         input int k);
    int  n_esp;
    int  last;
    bit  ok;
    bit  act;
    bit  fim;
    ok    = (k <= TMAX);
    n_esp = ok ? k : TMAX;
    last  = n_esp + 3;
    for (int c = 0; c <= last; c++) begin
      act = (c >= 1) && (c <= n_esp + 1);
      fim = (c == n_esp + 2);
      if (c == 0) begin
        req_escrita  = w;
        req_leitura  = r;
        endereco     = a;
        dado_escrita = wd;
        mem_ready    = 1'b0;
        mem_rdata    = 16'($urandom);
      end else begin
        endereco     = 16'($urandom);
        dado_escrita = 16'($urandom);
        req_leitura  = (c < last) ? 1'($urandom) : 1'b0;
        req_escrita  = (c < last) ? 1'($urandom) : 1'b0;
        if (c >= 2 && c <= n_esp + 1)
          mem_ready = (c - 1 == k);
        else
          mem_ready = 1'($urandom);
        mem_rdata = (c - 1 == k) ? rd : 16'($urandom);
      end
      if (fim) begin
        if (ok && !w) exp_dado = rd;
        if (!ok) exp_erro = 1'b1;
      end
      @(negedge clk);
      check("stall", 32'(stall), 32'(c <= n_esp + 1));
      check("mem_req", 32'(mem_req), 32'(act));
      check("concluido", 32'(concluido), 32'(fim));
      if (act) begin
        check("mem_we", 32'(mem_we), 32'(w));
        check("mem_addr", 32'(mem_addr), 32'(a));
        if (w) check("mem_wdata", 32'(mem_wdata), 32'(wd));
      end
      check("dado_lido", 32'(dado_lido), 32'(exp_dado));
      check("erro_timeout", 32'(erro_timeout),
            32'(exp_erro));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_mid_access();
    req_leitura = 1'b1;
    req_escrita = 1'b0;
    endereco    = 16'h0040;
    @(posedge clk); #1;
    req_leitura = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n       = 1'b0;
    req_leitura = 1'b1;
    mem_ready   = 1'b1;
    mem_rdata   = 16'hDEAD;
    exp_dado    = '0;
    exp_erro    = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dado", 32'(dado_lido), 32'd0);
    check("rst_erro", 32'(erro_timeout), 32'd0);
    @(negedge clk);
    check("rst_conc", 32'(concluido), 32'd0);
    @(posedge clk); #1;
    check("rst_conc2", 32'(concluido), 32'd0);
    rst_n       = 1'b1;
    req_leitura = 1'b0;
    mem_ready   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w, r;
    int          k;
    req_leitura = 1'b1;
    req_escrita = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_we", 32'(mem_we), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_wdata", 32'(mem_wdata), 32'd0);
    check("reset_dado", 32'(dado_lido), 32'd0);
    check("reset_conc", 32'(concluido), 32'd0);
    check("reset_erro", 32'(erro_timeout), 32'd0);
    rst_n = 1'b1;

    run_txn(1'b0, 1'b1, 16'h0010, 16'h0, 16'hBEEF, 2);
    run_txn(1'b1, 1'b0, 16'h00FF, 16'h1234, 16'h5555, 3);
    run_txn(1'b1, 1'b1, 16'h0A0A, 16'hCAFE, 16'h7777, 1);
    run_txn(1'b0, 1'b1, 16'h0020, 16'h0, 16'hA5A5, TMAX);
    run_txn(1'b0, 1'b1, 16'h0030, 16'h0, 16'h1111, TMAX + 1);
    run_txn(1'b0, 1'b1, 16'h0031, 16'h0, 16'h2222, 1);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      k = int'($urandom_range(1, TMAX + 2));
      run_txn(w, r, 16'($urandom), 16'($urandom),
              16'($urandom), k);
    end

    reset_mid_access();
    run_txn(1'b0, 1'b1, 16'h0050, 16'h0, 16'h3C3C, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
